program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 117 +++++++++++
 tb/tb_program_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Program counter sequencer with a return-address stack.
// Sticky overflow/underflow flags record CALL-on-full and RET-on-empty.
module program_sequencer #(
  parameter int                 ADDR_W      = 11,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               PCenable,
  input  logic [2:0]                         op,
  input  logic                               cond,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  offset,
  output logic [ADDR_W-1:0]                  PCout,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_plus1;
  logic [SP_W-1:0]   sp_minus1;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign sp_minus1 = sp_q - SP_W'(1);
  // Entry sp_q is the next free slot; sp_q-1 holds the top of stack.
  assign push_idx  = IDX_W'(sp_q);
  assign pop_idx   = IDX_W'(sp_minus1);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (PCenable) begin
      case (op)
        OP_BR:   pc_d = cond ? (pc_q + offset) : pc_plus1;
        OP_JMP:  pc_d = target;
        OP_CALL: begin
          pc_d = target;
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[push_idx] = pc_plus1;
            sp_d              = sp_q + SP_W'(1);
          end
        end
        OP_RET: begin
          if (empty_q) begin
            pc_d  = pc_plus1;
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_minus1;
          end
        end
        OP_HOLD: pc_d = pc_q;
        default: pc_d = pc_plus1;
      endcase
    end
    // Flags are registered alongside sp_count so they always match it.
    full_d  = (sp_d == SP_MAX);
    empty_d = (sp_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign PCout       = pc_q;
  assign sp_count    = sp_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_program_sequencer;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int SP_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              PCenable;
  logic [2:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] PCout;
  logic [SP_W-1:0]   sp_count;
  logic              stack_full;
  logic              stack_empty;
  logic              ovf_err;
  logic              unf_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                m_pc;
  logic [ADDR_W-1:0] m_stk[$];
  logic              m_ovf;
  logic              m_unf;

  program_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk(clk), .reset(reset), .PCenable(PCenable), .op(op), .cond(cond),
    .target(target), .offset(offset), .PCout(PCout), .sp_count(sp_count),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1ns past it.
  task automatic cycle(input logic rst, input logic en, input logic [2:0] o,
                       input logic c, input logic [ADDR_W-1:0] t,
                       input logic [ADDR_W-1:0] off);
    reset = rst; PCenable = en; op = o; cond = c; target = t; offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
    reset = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [2:0] o,
                            input logic c, input int t, input int off);
    if (rst) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (en) begin
      if (o == 3'd1) m_pc = c ? (m_pc + off) % 2048 : (m_pc + 1) % 2048;
      else if (o == 3'd2) m_pc = t;
      else if (o == 3'd3) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(ADDR_W'((m_pc + 1) % 2048));
        else m_ovf = 1'b1;
        m_pc = t;
      end else if (o == 3'd4) begin
        if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
        else begin m_pc = (m_pc + 1) % 2048; m_unf = 1'b1; end
      end else if (o == 3'd5) m_pc = m_pc;
      else m_pc = (m_pc + 1) % 2048;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({PCout, sp_count, stack_empty, stack_full, ovf_err, unf_err} !==
        {11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: pc=%h sp=%0d e=%b f=%b o=%b u=%b, required pc=000 sp=0 e=1 f=0 o=0 u=0",
               PCout, sp_count, stack_empty, stack_full, ovf_err, unf_err);
    end
  endtask

  task automatic test_seq_stall();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b1, 3'd0, 1'b0, '0, '0);
      checks++;
      if (PCout !== 11'(i)) begin
        errors++; $display("FAIL seq_%0d: pc=%h required %h", i, PCout, 11'(i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 3'd2, 1'b1, 11'h155, 11'h3);
      checks++;
      if (PCout !== 11'h003) begin
        errors++; $display("FAIL stall_%0d: pc=%h required 003", i, PCout);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h010, '0);
    cycle(1'b0, 1'b1, 3'd1, 1'b1, '0, 11'h7FC);
    checks++;
    if (PCout !== 11'h00C) begin errors++; $display("FAIL br_taken: pc=%h required 00c", PCout); end
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h010, '0);
    cycle(1'b0, 1'b1, 3'd1, 1'b0, '0, 11'h7FC);
    checks++;
    if (PCout !== 11'h011) begin errors++; $display("FAIL br_not_taken: pc=%h required 011", PCout); end
    cycle(1'b0, 1'b1, 3'd5, 1'b1, 11'h123, 11'h4);
    checks++;
    if (PCout !== 11'h011) begin errors++; $display("FAIL hold: pc=%h required 011", PCout); end
    cycle(1'b0, 1'b1, 3'd7, 1'b1, 11'h123, 11'h4);
    checks++;
    if (PCout !== 11'h012) begin errors++; $display("FAIL reserved_op: pc=%h required 012", PCout); end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h7FF, '0);
    cycle(1'b0, 1'b1, 3'd0, 1'b0, '0, '0);
    checks++;
    if (PCout !== 11'h000) begin errors++; $display("FAIL wrap_seq: pc=%h required 000", PCout); end
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h7FE, '0);
    cycle(1'b0, 1'b1, 3'd1, 1'b1, '0, 11'h005);
    checks++;
    if (PCout !== 11'h003) begin errors++; $display("FAIL wrap_br: pc=%h required 003", PCout); end
  endtask

  task automatic test_call_ret();
    logic [2:0]        ops[4]   = '{3'd3, 3'd3, 3'd4, 3'd4};
    logic [ADDR_W-1:0] tgts[4]  = '{11'h100, 11'h200, 11'h000, 11'h000};
    logic [ADDR_W-1:0] exp_pc[4] = '{11'h100, 11'h200, 11'h101, 11'h006};
    logic [SP_W-1:0]   exp_sp[4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    do_reset();
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h005, '0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, ops[i], 1'b0, tgts[i], '0);
      checks++;
      if (PCout !== exp_pc[i] || sp_count !== exp_sp[i]) begin
        errors++;
        $display("FAIL call_ret_%0d: pc=%h sp=%0d required pc=%h sp=%0d",
                 i, PCout, sp_count, exp_pc[i], exp_sp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_ret[4] = '{11'h043, 11'h042, 11'h041, 11'h021};
    do_reset();
    cycle(1'b0, 1'b1, 3'd2, 1'b0, 11'h020, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 3'd3, 1'b0, 11'(12'h040 + i), '0);
      checks++;
      if (PCout !== 11'(12'h040 + i) || stack_full !== (i >= 3) ||
          ovf_err !== (i == 4) || sp_count !== 3'((i >= 3) ? 4 : i + 1)) begin
        errors++;
        $display("FAIL call_%0d: pc=%h sp=%0d full=%b ovf=%b", i, PCout, sp_count, stack_full, ovf_err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
      checks++;
      if (PCout !== exp_ret[i] || ovf_err !== 1'b1 || stack_full !== 1'b0) begin
        errors++;
        $display("FAIL pop_%0d: pc=%h ovf=%b full=%b required pc=%h ovf=1 full=0",
                 i, PCout, ovf_err, stack_full, exp_ret[i]);
      end
    end
    cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
    checks++;
    if (PCout !== 11'h022 || unf_err !== 1'b1 || sp_count !== 3'd0 || stack_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h unf=%b sp=%0d empty=%b required pc=022 unf=1 sp=0 empty=1",
               PCout, unf_err, sp_count, stack_empty);
    end
    cycle(1'b0, 1'b1, 3'd0, 1'b0, '0, '0);
    checks++;
    if (unf_err !== 1'b1 || ovf_err !== 1'b1) begin
      errors++; $display("FAIL sticky: ovf=%b unf=%b required 1 1", ovf_err, unf_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 1'b1, 3'd3, 1'b0, 11'h010, '0);
    cycle(1'b0, 1'b1, 3'd3, 1'b0, 11'h020, '0);
    cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 3'd3, 1'b0, 11'h030, '0);
    cycle(1'b0, 1'b1, 3'd3, 1'b0, 11'h040, '0);
    checks++;
    if (sp_count !== 3'd2 || unf_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: sp=%0d unf=%b required sp=2 unf=1", sp_count, unf_err);
    end
    cycle(1'b1, 1'b1, 3'd3, 1'b1, 11'h077, '0);
    reset = 1'b0;
    checks++;
    if ({PCout, sp_count, stack_empty, stack_full, ovf_err, unf_err} !==
        {11'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: pc=%h sp=%0d e=%b f=%b o=%b u=%b, required pc=000 sp=0 e=1 f=0 o=0 u=0",
               PCout, sp_count, stack_empty, stack_full, ovf_err, unf_err);
    end
    cycle(1'b0, 1'b1, 3'd4, 1'b0, '0, '0);
    checks++;
    if (PCout !== 11'h001 || unf_err !== 1'b1) begin
      errors++; $display("FAIL ret_after_reset: pc=%h unf=%b required 001 1", PCout, unf_err);
    end
  endtask

  task automatic test_random();
    logic       rst, en, c;
    logic [2:0] o;
    int         t, off;
    do_reset();
    model_step(1'b1, 1'b0, 3'd0, 1'b0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 5) != 0);
      o   = 3'($urandom_range(0, 7));
      c   = 1'($urandom_range(0, 1));
      t   = $urandom_range(0, 2047);
      off = $urandom_range(0, 2047);
      cycle(rst, en, o, c, 11'(t), 11'(off));
      model_step(rst, en, o, c, t, off);
      checks++;
      if (PCout !== 11'(m_pc) || sp_count !== 3'(m_stk.size()) ||
          stack_full !== (m_stk.size() == DEPTH) || stack_empty !== (m_stk.size() == 0) ||
          ovf_err !== m_ovf || unf_err !== m_unf) begin
        errors++;
        $display("FAIL rand_%0d: pc=%h sp=%0d f=%b e=%b o=%b u=%b required pc=%h sp=%0d o=%b u=%b",
                 i, PCout, sp_count, stack_full, stack_empty, ovf_err, unf_err,
                 11'(m_pc), m_stk.size(), m_ovf, m_unf);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PCenable = 1'b0; op = '0; cond = 1'b0; target = '0; offset = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_seq_stall();
    test_branch();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
